// File: rtl/arbiter_pkg.sv
// Shared definitions for the three-requester round-robin arbiter.
// Holds the requester count, the index type and the pointer value loaded at reset.
package arbiter_pkg;

  localparam int N_REQ = 3;

  typedef logic [1:0] req_idx_t;

  localparam req_idx_t LAST_RST = 2'd2;

  function automatic logic [N_REQ-1:0] onehot_of(input req_idx_t idx);
    logic [N_REQ-1:0] result;
    result = '0;
    case (idx)
      2'd0:    result = 3'b001;
      2'd1:    result = 3'b010;
      default: result = 3'b100;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/arbiter_3_rr_pick.sv
// Combinational round-robin selector: the first request after the last winner
// wins, and the last winner itself is tried at the end.
module rr_pick
  import arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  req_idx_t         last,
  output logic             valid,
  output req_idx_t         idx,
  output logic [N_REQ-1:0] onehot
);

  req_idx_t base;
  req_idx_t cand1;
  req_idx_t cand2;

  // The pointer encoding 3 is never stored, so fold it onto 2 if it ever appears
  assign base  = (last == 2'd3) ? 2'd2 : last;
  assign cand1 = (base == 2'd2) ? 2'd0 : base + 2'd1;
  assign cand2 = (base == 2'd0) ? 2'd2 : base - 2'd1;

  always_comb begin
    valid  = 1'b0;
    idx    = base;
    onehot = '0;
    if (req[cand1]) begin
      valid  = 1'b1;
      idx    = cand1;
      onehot = onehot_of(cand1);
    end else if (req[cand2]) begin
      valid  = 1'b1;
      idx    = cand2;
      onehot = onehot_of(cand2);
    end else if (req[base]) begin
      valid  = 1'b1;
      idx    = base;
      onehot = onehot_of(base);
    end
  end

endmodule

// File: rtl/arbiter_3.sv
// Three-requester round-robin arbiter with registered one-hot grants.
// With HOLD set, a grant stays with its owner for as long as that owner's request is high.
module arbiter_3
  import arbiter_pkg::*;
#(
  parameter bit HOLD = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic X0,
  input  logic X1,
  input  logic X2,
  output logic Y0,
  output logic Y1,
  output logic Y2
);

  logic [N_REQ-1:0] x;
  logic [N_REQ-1:0] y;
  req_idx_t         last;

  logic             pick_valid;
  req_idx_t         pick_idx;
  logic [N_REQ-1:0] pick_onehot;
  logic             hold_grant;

  assign x = {X2, X1, X0};
  assign {Y2, Y1, Y0} = y;

  rr_pick u_pick (
    .req    (x),
    .last   (last),
    .valid  (pick_valid),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  // y is one-hot or zero, so any overlap with x means the current owner still requests
  assign hold_grant = HOLD && (|(y & x));

  always_ff @(posedge clk) begin
    if (rst) begin
      y    <= '0;
      last <= LAST_RST;
    end else if (hold_grant) begin
      y    <= y;
      last <= last;
    end else if (pick_valid) begin
      y    <= pick_onehot;
      last <= pick_idx;
    end else begin
      y    <= '0;
      last <= last;
    end
  end

endmodule

// File: tb/tb_arbiter_3.sv
// Self-checking bench for arbiter_3: a directed vector table, a few hand-written
// sequences, and a random-request run checked against a small reference model.
module tb_arbiter_3;

  typedef struct {
    logic       rst;
    logic [2:0] x;
    logic [2:0] y;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic X0 = 1'b0;
  logic X1 = 1'b0;
  logic X2 = 1'b0;
  logic Y0, Y1, Y2;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  logic [2:0] m_y;
  int         m_last;

  arbiter_3 dut (
    .clk (clk),
    .rst (rst),
    .X0  (X0),
    .X1  (X1),
    .X2  (X2),
    .Y0  (Y0),
    .Y1  (Y1),
    .Y2  (Y2)
  );

  always #5 clk = ~clk;

  task automatic addVec(input logic r, input logic [2:0] x, input logic [2:0] y);
    vec_t v;
    v.rst = r;
    v.x   = x;
    v.y   = y;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic r, input logic [2:0] x);
    @(negedge clk);
    rst = r;
    {X2, X1, X0} = x;
  endtask

  task automatic checkOutput(input string name, input logic [2:0] expected);
    checks++;
    if ({Y2, Y1, Y0} !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got Y=%b expected Y=%b", name, {Y2, Y1, Y0}, expected);
    end
  endtask

  task automatic stepAndCheck(input string name, input logic r, input logic [2:0] x,
                              input logic [2:0] expected);
    applyStimulus(r, x);
    @(posedge clk);
    #1;
    checkOutput(name, expected);
  endtask

  // Reference model written as an explicit priority scan
  task automatic modelStep(input logic [2:0] x);
    bit found;
    int i;
    found = 1'b0;
    if ((m_y & x) != 3'b000) begin
      return;
    end
    for (int k = 1; k <= 3; k++) begin
      i = (m_last + k) % 3;
      if (!found && x[i]) begin
        m_y    = 3'b000;
        m_y[i] = 1'b1;
        m_last = i;
        found  = 1'b1;
      end
    end
    if (!found) m_y = 3'b000;
  endtask

  initial begin
    logic [2:0] xr;
    logic [2:0] yr;

    // Idle after reset
    addVec(1'b1, 3'b000, 3'b000);
    for (int i = 0; i < 5; i++) addVec(1'b0, 3'b000, 3'b000);
    // Single requester: grant, hold, release
    addVec(1'b1, 3'b000, 3'b000);
    addVec(1'b0, 3'b001, 3'b001);
    addVec(1'b0, 3'b001, 3'b001);
    addVec(1'b0, 3'b000, 3'b000);
    // All request; each holder drops for one cycle after two cycles of grant
    addVec(1'b1, 3'b111, 3'b000);
    addVec(1'b0, 3'b111, 3'b001);
    addVec(1'b0, 3'b111, 3'b001);
    addVec(1'b0, 3'b110, 3'b010);
    addVec(1'b0, 3'b111, 3'b010);
    addVec(1'b0, 3'b111, 3'b010);
    addVec(1'b0, 3'b101, 3'b100);
    addVec(1'b0, 3'b111, 3'b100);
    addVec(1'b0, 3'b111, 3'b100);
    addVec(1'b0, 3'b011, 3'b001);
    // Y=010 held, then X=101 with last=1
    addVec(1'b0, 3'b010, 3'b010);
    addVec(1'b0, 3'b010, 3'b010);
    addVec(1'b0, 3'b101, 3'b100);
    addVec(1'b0, 3'b100, 3'b100);
    addVec(1'b0, 3'b001, 3'b001);
    // Reset while Y=100 and all requesting
    addVec(1'b0, 3'b100, 3'b100);
    addVec(1'b1, 3'b111, 3'b000);
    addVec(1'b0, 3'b111, 3'b001);
    // Lone requester is re-granted; holder kept despite a competitor
    addVec(1'b0, 3'b000, 3'b000);
    addVec(1'b0, 3'b001, 3'b001);
    addVec(1'b0, 3'b011, 3'b001);
    addVec(1'b0, 3'b010, 3'b010);

    for (int i = 0; i < vecs.size(); i++) begin
      stepAndCheck($sformatf("vec%0d", i), vecs[i].rst, vecs[i].x, vecs[i].y);
    end

    // No combinational path: a mid-cycle change on X must not move Y before the edge
    stepAndCheck("comb_setup", 1'b0, 3'b010, 3'b010);
    @(negedge clk);
    {X2, X1, X0} = 3'b101;
    #2;
    checkOutput("no_comb_path", 3'b010);
    @(posedge clk);
    #1;
    checkOutput("after_comb_edge", 3'b100);

    // Random run against the model, plus structural invariants
    stepAndCheck("rand_reset", 1'b1, 3'b000, 3'b000);
    m_y    = 3'b000;
    m_last = 2;
    for (int n = 0; n < 200; n++) begin
      xr = 3'($urandom_range(0, 7));
      applyStimulus(1'b0, xr);
      modelStep(xr);
      @(posedge clk);
      #1;
      checkOutput($sformatf("rand%0d", n), m_y);
      yr = {Y2, Y1, Y0};
      checks++;
      if ($countones(yr) > 1) begin
        errors++;
        $display("[TB] FAIL onehot%0d: got Y=%b expected at most one grant", n, yr);
      end
      checks++;
      if ((yr & ~xr) != 3'b000) begin
        errors++;
        $display("[TB] FAIL grant_req%0d: got Y=%b expected subset of X=%b", n, yr, xr);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
